// File: rtl/sd_cmd_responder_if.sv
// SD command-line bundle between the card-side responder and its neighbours:
// host clock and pad signals plus the command/response handshake with card logic.
interface sd_cmd_responder_if;
  logic         sd_clk;
  logic         cmd_in;
  logic         cmd_out;
  logic         cmd_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_err;
  logic         resp_valid;
  logic         resp_long;
  logic [126:0] resp_data;
  logic         resp_ready;
  logic         busy;

  // Host pads and card logic side
  modport master (
    output sd_clk, cmd_in, resp_valid, resp_long, resp_data,
    input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_err, resp_ready, busy
  );

  // Responder side
  modport slave (
    input  sd_clk, cmd_in, resp_valid, resp_long, resp_data,
    output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_err, resp_ready, busy
  );
endinterface

// File: rtl/sd_cmd_responder.sv
// SD card-side command responder: receives 48-bit host commands on the CMD
// line (sampled on sd_clk rise), checks CRC7/end bit, reports them to card
// logic, then transmits a 48-bit or 136-bit response driven on sd_clk fall.
// sd_clk is oversampled by clk through a 2-FF synchronizer.
module sd_cmd_responder #(
  parameter int NCR_MAX = 64
) (
  input logic           clk,
  input logic           rst,
  sd_cmd_responder_if.slave sd
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);
  localparam logic [NCR_W-1:0] NCR_LIM = NCR_W'(NCR_MAX);
  localparam logic [NCR_W-1:0] NCR_MIN = NCR_W'(2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX        = 3'd1,
    WAIT_RESP = 3'd2,
    TX        = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t state, next_state;

  // CRC7 (x^7 + x^3 + 1), one bit, MSB first
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 over the 40 leading bits of a short response
  function automatic logic [6:0] crc7_word(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic       sd_clk_s1, sd_clk_s2, sd_clk_s3;
  logic       cmd_s1, cmd_s2;
  logic       rise, fall;

  logic [44:0]      rx_shift;   // received bits 45..1 of the frame, bit 1 at [0]
  logic [5:0]       rx_cnt;     // bits received so far (start bit = 0)
  logic [6:0]       crc;
  logic [NCR_W-1:0] ncr_cnt;
  logic [135:0]     tx_shift;
  logic [7:0]       tx_cnt;     // bits still to drive, including the current one
  logic             rel_done;

  logic        drv_bit, drv_en;
  logic        valid_pulse, err_hold, ready_pulse;
  logic [5:0]  idx_hold;
  logic [31:0] arg_hold;

  logic rx_start, rx_shift_en, rx_done, tx_load;
  logic frame_err;

  logic [39:0]  short_body;
  logic [47:0]  short_frame;
  logic [135:0] long_frame;

  assign rise = sd_clk_s2 & ~sd_clk_s3;
  assign fall = ~sd_clk_s2 & sd_clk_s3;

  // When the end bit arrives, rx_shift[6:0] holds the received CRC field
  assign frame_err = (rx_shift[6:0] != crc) || !cmd_s2;

  assign short_body  = {2'b00, sd.resp_data[37:0]};
  assign short_frame = {short_body, crc7_word(short_body), 1'b1};
  assign long_frame  = {2'b00, 6'b111111, sd.resp_data, 1'b1};

  assign sd.cmd_out    = drv_bit;
  assign sd.cmd_oe     = drv_en;
  assign sd.cmd_valid  = valid_pulse;
  assign sd.cmd_index  = idx_hold;
  assign sd.cmd_arg    = arg_hold;
  assign sd.cmd_err    = err_hold;
  assign sd.resp_ready = ready_pulse;
  assign sd.busy       = (state != IDLE);

  // Synchronize sd_clk and cmd_in together so cmd is aligned with the strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_clk_s1 <= 1'b0;
      sd_clk_s2 <= 1'b0;
      sd_clk_s3 <= 1'b0;
      cmd_s1    <= 1'b1;
      cmd_s2    <= 1'b1;
    end else begin
      sd_clk_s1 <= sd.sd_clk;
      sd_clk_s2 <= sd_clk_s1;
      sd_clk_s3 <= sd_clk_s2;
      cmd_s1    <= sd.cmd_in;
      cmd_s2    <= cmd_s1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    next_state  = state;
    rx_start    = 1'b0;
    rx_shift_en = 1'b0;
    rx_done     = 1'b0;
    tx_load     = 1'b0;
    case (state)
      IDLE: begin
        if (rise && !cmd_s2) begin
          rx_start   = 1'b1;
          next_state = RX;
        end
      end
      RX: begin
        if (rise) begin
          if (rx_cnt == 6'd1 && !cmd_s2) begin
            next_state = IDLE;                 // transmission bit must be 1
          end else begin
            rx_shift_en = 1'b1;
            if (rx_cnt == 6'd47) begin
              rx_done    = 1'b1;
              next_state = frame_err ? IDLE : WAIT_RESP;
            end
          end
        end
      end
      WAIT_RESP: begin
        if (ncr_cnt >= NCR_MIN && sd.resp_valid) begin
          tx_load    = 1'b1;
          next_state = TX;
        end else if (ncr_cnt == NCR_LIM) begin
          next_state = IDLE;
        end
      end
      TX: begin
        if (fall && tx_cnt == 8'd1) next_state = RELEASE;
      end
      RELEASE: begin
        if (fall && rel_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters, CRC, command report, handshake pulses and pad drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt      <= 6'd0;
      crc         <= 7'd0;
      ncr_cnt     <= '0;
      tx_cnt      <= 8'd0;
      rel_done    <= 1'b0;
      drv_bit     <= 1'b1;
      drv_en      <= 1'b0;
      valid_pulse <= 1'b0;
      err_hold    <= 1'b0;
      ready_pulse <= 1'b0;
      idx_hold    <= 6'd0;
      arg_hold    <= 32'd0;
    end else begin
      valid_pulse <= rx_done;
      ready_pulse <= tx_load;

      // The start bit is 0, so the CRC after it is still 0
      if (rx_start) begin
        rx_cnt <= 6'd1;
        crc    <= 7'd0;
      end else if (rx_shift_en) begin
        rx_cnt <= rx_cnt + 6'd1;
        if (rx_cnt <= 6'd39) crc <= crc7_step(crc, cmd_s2);
      end

      if (rx_done) begin
        idx_hold <= rx_shift[44:39];
        arg_hold <= rx_shift[38:7];
        err_hold <= frame_err;
        ncr_cnt  <= '0;
      end else if (state == WAIT_RESP && fall && ncr_cnt != NCR_LIM) begin
        ncr_cnt <= ncr_cnt + NCR_W'(1);
      end

      if (tx_load) begin
        tx_cnt   <= sd.resp_long ? 8'd136 : 8'd48;
        rel_done <= 1'b0;
      end else if (state == TX && fall) begin
        drv_bit <= tx_shift[135];
        drv_en  <= 1'b1;
        tx_cnt  <= tx_cnt - 8'd1;
      end else if (state == RELEASE && fall) begin
        drv_bit <= 1'b1;
        if (rel_done) begin
          drv_en <= 1'b0;
        end else begin
          drv_en   <= 1'b1;
          rel_done <= 1'b1;
        end
      end
    end
  end

  // Frame shifters carry data only and need no reset
  always_ff @(posedge clk) begin
    if (rx_start || rx_shift_en) rx_shift <= {rx_shift[43:0], cmd_s2};
    if (tx_load)                 tx_shift <= sd.resp_long ? long_frame : {short_frame, 88'd0};
    else if (state == TX && fall) tx_shift <= {tx_shift[134:0], 1'b1};
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: acts as SD host (sd_clk = clk/8,
// command bits driven on fall, response sampled just before rise) and as
// card logic supplying responses.
module tb_sd_cmd_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   vcnt = 0;
  int   rcnt = 0;
  logic v_err = 1'b0;
  logic last_o, last_e;
  logic oe_any;
  logic got;
  int   gap;
  logic [135:0] r;

  sd_cmd_responder_if ifc();

  sd_cmd_responder #(.NCR_MAX(64)) dut (
    .clk (clk),
    .rst (rst),
    .sd  (ifc.slave)
  );

  always #5 clk = ~clk;

  // Record command reports and response handshakes
  always @(posedge clk) begin
    if (ifc.cmd_valid) begin
      vcnt  <= vcnt + 1;
      v_err <= ifc.cmd_err;
    end
    if (ifc.resp_ready) rcnt <= rcnt + 1;
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sd_clk period: drive on fall, sample the card just before rise
  task automatic sd_bit(input logic b);
    ifc.sd_clk = 1'b0;
    ifc.cmd_in = b;
    #40;
    last_o = ifc.cmd_out;
    last_e = ifc.cmd_oe;
    ifc.sd_clk = 1'b1;
    #40;
  endtask

  task automatic idle(input int n);
    oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      sd_bit(1'b1);
      oe_any = oe_any | last_e;
    end
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) sd_bit(f[i]);
  endtask

  // Wait (bounded) for the start bit, then collect nbits of response MSB first
  task automatic get_resp(input int nbits);
    r = '0;
    got = 1'b0;
    gap = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      sd_bit(1'b1);
      if (last_e === 1'b1) begin
        got = 1'b1;
        gap = c;
        r[nbits-1] = last_o;
      end
    end
    if (got) begin
      for (int k = nbits - 2; k >= 0; k--) begin
        sd_bit(1'b1);
        r[k] = last_o;
      end
    end
  endtask

  task automatic check_release(input string tag);
    sd_bit(1'b1);
    check({tag, "_rel_bit"}, 136'(last_o), 136'(1));
    check({tag, "_rel_oe"},  136'(last_e), 136'(1));
    sd_bit(1'b1);
    check({tag, "_off_oe"},  136'(last_e), 136'(0));
    check({tag, "_idle"},    136'(ifc.busy), 136'(0));
  endtask

  initial begin
    ifc.sd_clk     = 1'b1;
    ifc.cmd_in     = 1'b1;
    ifc.resp_valid = 1'b0;
    ifc.resp_long  = 1'b0;
    ifc.resp_data  = '0;
    #42;
    check("rst_oe",    136'(ifc.cmd_oe), 136'(0));
    check("rst_out",   136'(ifc.cmd_out), 136'(1));
    check("rst_valid", 136'(ifc.cmd_valid), 136'(0));
    check("rst_busy",  136'(ifc.busy), 136'(0));
    check("rst_ready", 136'(ifc.resp_ready), 136'(0));
    check("rst_err",   136'(ifc.cmd_err), 136'(0));
    check("rst_index", 136'(ifc.cmd_index), 136'(0));
    check("rst_arg",   136'(ifc.cmd_arg), 136'(0));
    #18;
    rst = 1'b0;
    idle(4);

    // CMD0 without a response: timeout back to IDLE, CMD line untouched
    send_cmd(48'h40_00000000_95);
    check("cmd0_valid", 136'(vcnt), 136'(1));
    check("cmd0_index", 136'(ifc.cmd_index), 136'(0));
    check("cmd0_arg",   136'(ifc.cmd_arg), 136'(0));
    check("cmd0_err",   136'(v_err), 136'(0));
    idle(62);
    check("cmd0_wait_busy", 136'(ifc.busy), 136'(1));
    check("cmd0_wait_oe",   136'(oe_any), 136'(0));
    idle(4);
    check("cmd0_timeout",   136'(ifc.busy), 136'(0));
    check("cmd0_no_ready",  136'(rcnt), 136'(0));

    // CMD8 with a short R7 response; resp_valid in IDLE is ignored
    ifc.resp_valid = 1'b1;
    ifc.resp_long  = 1'b0;
    ifc.resp_data  = 127'h08_000001AA;
    idle(3);
    check("idle_resp_ignored", 136'(rcnt), 136'(0));
    send_cmd(48'h48_000001AA_87);
    check("cmd8_valid", 136'(vcnt), 136'(2));
    check("cmd8_index", 136'(ifc.cmd_index), 136'(8));
    check("cmd8_arg",   136'(ifc.cmd_arg), 136'(32'h000001AA));
    check("cmd8_err",   136'(v_err), 136'(0));
    get_resp(48);
    check("cmd8_got",   136'(got), 136'(1));
    check("cmd8_gap",   136'(gap), 136'(2));
    check("cmd8_resp",  r, 136'(48'h08_000001AA_13));
    check("cmd8_ready", 136'(rcnt), 136'(1));
    check_release("cmd8");

    // CMD17 with bad end bit, then CMD0 with bad CRC: error, no response
    send_cmd(48'h51_00000000_54);
    check("cmd17_valid", 136'(vcnt), 136'(3));
    check("cmd17_index", 136'(ifc.cmd_index), 136'(17));
    check("cmd17_err",   136'(v_err), 136'(1));
    idle(8);
    check("cmd17_no_oe",    136'(oe_any), 136'(0));
    check("cmd17_idle",     136'(ifc.busy), 136'(0));
    send_cmd(48'h40_00000000_97);
    check("badcrc_valid", 136'(vcnt), 136'(4));
    check("badcrc_err",   136'(v_err), 136'(1));
    idle(8);
    check("badcrc_no_oe",   136'(oe_any), 136'(0));
    check("err_no_ready",   136'(rcnt), 136'(1));

    // Long R2 response with payload 1
    ifc.resp_long = 1'b1;
    ifc.resp_data = 127'h1;
    send_cmd(48'h48_000001AA_87);
    check("long_valid", 136'(vcnt), 136'(5));
    check("long_err",   136'(v_err), 136'(0));
    get_resp(136);
    check("long_got",   136'(got), 136'(1));
    check("long_gap",   136'(gap), 136'(2));
    check("long_resp",  r, {8'h3F, 126'd0, 2'b11});
    check("long_ready", 136'(rcnt), 136'(2));
    check_release("long");

    // Transmission bit 0 aborts silently; next CMD0 accepted
    ifc.resp_valid = 1'b0;
    ifc.resp_long  = 1'b0;
    sd_bit(1'b0);
    sd_bit(1'b0);
    idle(6);
    check("txbit_no_valid", 136'(vcnt), 136'(5));
    check("txbit_idle",     136'(ifc.busy), 136'(0));
    send_cmd(48'h40_00000000_95);
    check("after_abort_valid", 136'(vcnt), 136'(6));
    check("after_abort_err",   136'(v_err), 136'(0));
    check("after_abort_index", 136'(ifc.cmd_index), 136'(0));
    idle(66);
    check("after_abort_timeout", 136'(ifc.busy), 136'(0));

    // Reset in the middle of a response, then a clean CMD8
    ifc.resp_valid = 1'b1;
    ifc.resp_data  = 127'h08_000001AA;
    send_cmd(48'h48_000001AA_87);
    for (int i = 0; i < 22; i++) sd_bit(1'b1);
    ifc.sd_clk = 1'b0;
    ifc.cmd_in = 1'b1;
    #30;
    check("midtx_oe", 136'(ifc.cmd_oe), 136'(1));
    rst = 1'b1;
    #1;
    check("rst_async_oe",   136'(ifc.cmd_oe), 136'(0));
    check("rst_async_out",  136'(ifc.cmd_out), 136'(1));
    check("rst_async_busy", 136'(ifc.busy), 136'(0));
    #18;
    rst = 1'b0;
    #31;
    ifc.sd_clk = 1'b1;
    #40;
    idle(4);
    check("post_rst_no_oe", 136'(oe_any), 136'(0));
    send_cmd(48'h48_000001AA_87);
    check("post_rst_valid", 136'(vcnt), 136'(8));
    check("post_rst_err",   136'(v_err), 136'(0));
    check("post_rst_arg",   136'(ifc.cmd_arg), 136'(32'h000001AA));
    get_resp(48);
    check("post_rst_got",   136'(got), 136'(1));
    check("post_rst_gap",   136'(gap), 136'(2));
    check("post_rst_resp",  r, 136'(48'h08_000001AA_13));
    check_release("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
